// File: rtl/dffa_strobe_seq.sv
// Strobe sequencer for an async set/reset flop: issues one active-low clear or
// preset pulse per accepted request, followed by a dead gap with both strobes high.
module dffa_strobe_seq #(
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_op,
  output logic req_ready,
  output logic resetb,
  output logic setb,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_e;

  // Counters load N-1 so that a terminal count of zero marks the last cycle.
  localparam logic [7:0] PulseLoad = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GapLoad   = (GAP_CYC == 0) ? 8'd0 : 8'(GAP_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;
  logic       resetb_q, resetb_d;
  logic       setb_q, setb_d;
  logic       done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    resetb_d = resetb_q;
    setb_d   = setb_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d  = 1'b1;
        resetb_d = 1'b1;
        setb_d   = 1'b1;
        if (req_valid && ready_q) begin
          state_d  = PULSE;
          cnt_d    = PulseLoad;
          ready_d  = 1'b0;
          // Exactly one strobe is driven low, chosen by the single op bit.
          resetb_d = req_op;
          setb_d   = !req_op;
        end
      end
      PULSE: begin
        if (cnt_q == 8'd0) begin
          resetb_d = 1'b1;
          setb_d   = 1'b1;
          done_d   = 1'b1;
          if (GAP_CYC == 0) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = GapLoad;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        ready_d  = 1'b0;
        resetb_d = 1'b1;
        setb_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      ready_q  <= 1'b0;
      resetb_q <= 1'b1;
      setb_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      resetb_q <= resetb_d;
      setb_q   <= setb_d;
      done_q   <= done_d;
    end
  end

  assign req_ready = ready_q;
  assign resetb    = resetb_q;
  assign setb      = setb_q;
  assign done      = done_q;

endmodule
